pc_sequencer: RTL

- Owns the program counter register and sequences every PC update: sequential advance, conditional PC-relative branch, absolute jump, stall and halt.
- Computes the branch target internally as PC+4 plus the word-scaled offset, modulo 2^PC_WIDTH.
- Raises a one-cycle Flush so the fetch/decode stages squash the wrong-path instruction after a redirect.
- Sits between instruction fetch (drives PC) and decode/ALU (supplies branch condition, offset and jump target).

---
 rtl/pc_sequencer.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/pc_sequencer.sv
// ---------------------------------------------------------------------------
// pc_sequencer
// Owns the program counter and decides every PC update: sequential advance,
// conditional PC-relative branch, absolute jump, stall and halt. After a
// redirect it raises Flush for one cycle so fetch/decode can squash the
// wrong-path instruction.
//
// Ports:
//   clk            system clock, rising edge
//   rst_n          asynchronous active-low reset
//   Stall          hold PC and state this cycle
//   BranchEn       current instruction is a conditional branch
//   Zero           branch condition; branch taken when BranchEn & Zero
//   Offset         branch word offset (zero-extended, wraps modulo PC range)
//   Jump           current instruction is an absolute jump
//   JumpTarget     jump word address
//   Halt           request to freeze the sequencer
//   Resume         leave the halted state
//   PC             current fetch address (registered)
//   PCNext         PC + 4 (combinational)
//   Flush          squash the wrong-path instruction (registered)
//   Halted         high while halted (registered)
//   RedirectCount  saturating count of taken redirects
// ---------------------------------------------------------------------------
module pc_sequencer #(
   parameter int PC_WIDTH  = 6,
   parameter int OFF_WIDTH = 8,
   parameter int JT_WIDTH  = 8,
   parameter int RESET_PC  = 0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 Stall,
   input  logic                 BranchEn,
   input  logic                 Zero,
   input  logic [OFF_WIDTH-1:0] Offset,
   input  logic                 Jump,
   input  logic [JT_WIDTH-1:0]  JumpTarget,
   input  logic                 Halt,
   input  logic                 Resume,
   output logic [PC_WIDTH-1:0]  PC,
   output logic [PC_WIDTH-1:0]  PCNext,
   output logic                 Flush,
   output logic                 Halted,
   output logic [7:0]           RedirectCount
);

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      FLUSH = 2'd1,
      HALT  = 2'd2
   } state_t;

   // Intermediate widths large enough to hold the word-scaled fields before
   // they are truncated to the PC width; this keeps the arithmetic correct
   // whether the PC is narrower or wider than the scaled fields.
   localparam int OFF_W = (PC_WIDTH > OFF_WIDTH + 2) ? PC_WIDTH : OFF_WIDTH + 2;
   localparam int JT_W  = (PC_WIDTH > JT_WIDTH + 2)  ? PC_WIDTH : JT_WIDTH + 2;

   state_t              state;
   logic [OFF_W-1:0]    off_wide;
   logic [JT_W-1:0]     jt_wide;
   logic [PC_WIDTH-1:0] br_target;
   logic [PC_WIDTH-1:0] jmp_target;
   logic [7:0]          count_inc;
   logic                take_branch;

   // Address arithmetic, all modulo 2^PC_WIDTH. The offset is deliberately
   // not sign-extended: backward branches come from modular wrap-around.
   assign off_wide    = OFF_W'({Offset, 2'b00});
   assign jt_wide     = JT_W'({JumpTarget, 2'b00});
   assign PCNext      = PC + PC_WIDTH'(4);
   assign br_target   = PCNext + off_wide[PC_WIDTH-1:0];
   assign jmp_target  = jt_wide[PC_WIDTH-1:0];
   assign take_branch = BranchEn & Zero;

   // Redirect counter sticks at 255 instead of wrapping.
   assign count_inc = (RedirectCount == 8'hFF) ? RedirectCount : RedirectCount + 8'd1;

   // Sequencer FSM. Flush and Halted are registered copies of the state so
   // downstream stages see glitch-free flags. In RUN, priority is
   // Halt > Stall > Jump > taken branch > sequential advance. The FLUSH cycle
   // ignores Jump/BranchEn/Zero since they belong to the squashed instruction.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= RUN;
         PC            <= PC_WIDTH'(RESET_PC);
         Flush         <= 1'b0;
         Halted        <= 1'b0;
         RedirectCount <= 8'd0;
      end else begin
         case (state)
            RUN: begin
               if (Halt) begin
                  state  <= HALT;
                  Halted <= 1'b1;
               end else if (Stall) begin
                  state <= RUN;
               end else if (Jump) begin
                  PC            <= jmp_target;
                  state         <= FLUSH;
                  Flush         <= 1'b1;
                  RedirectCount <= count_inc;
               end else if (take_branch) begin
                  PC            <= br_target;
                  state         <= FLUSH;
                  Flush         <= 1'b1;
                  RedirectCount <= count_inc;
               end else begin
                  PC <= PCNext;
               end
            end
            FLUSH: begin
               Flush <= 1'b0;
               if (Halt) begin
                  state  <= HALT;
                  Halted <= 1'b1;
               end else begin
                  state <= RUN;
                  if (!Stall) begin
                     PC <= PCNext;
                  end
               end
            end
            HALT: begin
               if (Resume) begin
                  state  <= RUN;
                  Halted <= 1'b0;
               end
            end
            default: begin
               state  <= RUN;
               Flush  <= 1'b0;
               Halted <= 1'b0;
            end
         endcase
      end
   end

endmodule
